cm_link_rx: RTL and testbench

Parametrised receiver for the Xmega→FPGA chip-interconnect bus (CM data lines plus CLK_inter strobe). The strobe is synchronised into the CLK_50 domain, and CM beats are captured on each strobe rising edge. Beats are assembled into multi-beat words and buffered in a FIFO that drains through a valid/ready handshake. Framing timeouts and overflow are detected and reported. The block sits between the board pins and user logic (LED/SEG display, SPI bridge), replacing direct latching of CM on CLK_inter.

---
 rtl/cm_link_rx.sv | 89 ++++++++
 tb/tb_cm_link_rx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cm_link_rx.sv
// cm_link_rx: synchronises the Xmega strobe, assembles CM beats into words and buffers them in a FIFO
module cm_link_rx #(
  parameter int DATA_W  = 8,
  parameter int BEATS   = 2,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                         CLK_50,
  input  logic                         RST_n,
  input  logic [DATA_W-1:0]            CM,
  input  logic                         CLK_inter,
  output logic [DATA_W*BEATS-1:0]      word_out,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  output logic                         frame_err,
  input  logic                         clr_flags
);
  localparam int W  = DATA_W * BEATS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BEATS) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0]             s_q, s_d;
  logic [1:0][DATA_W-1:0] d_q, d_d;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [W-1:0]           asm_q, asm_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [W-1:0]           mem_q [DEPTH];
  logic [W-1:0]           mem_d [DEPTH];
  logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
  logic                   ov_q, ov_d, fe_q, fe_d;
  logic                   strobe, last, push, fire, full, empty, pop, drop;
  logic [W-1:0]           push_word;
  always_comb begin
    s_d        = {s_q[1:0], CLK_inter};
    d_d        = {d_q[0], CM};
    strobe     = s_q[1] & ~s_q[2];
    last       = beat_cnt_q == CW'(BEATS - 1);
    push       = strobe & last;
    fire       = ~strobe & (beat_cnt_q != '0) & (tmo_q == TW'(TIMEOUT - 1));
    empty      = wr_q == rd_q;
    full       = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    pop        = word_ready & ~empty;
    drop       = push & full & ~pop;
    push_word  = asm_q;
    push_word[W-1 -: DATA_W] = d_q[1];
    asm_d      = fire ? '0 : asm_q;
    if (strobe & ~last) asm_d[int'(beat_cnt_q)*DATA_W +: DATA_W] = d_q[1];
    beat_cnt_d = fire ? '0 : strobe ? (last ? '0 : beat_cnt_q + CW'(1)) : beat_cnt_q;
    tmo_d      = (strobe | fire | beat_cnt_q == '0) ? '0 : tmo_q + TW'(1);
    mem_d      = mem_q;
    if (push & ~drop) mem_d[wr_q[AW-1:0]] = push_word;
    wr_d       = wr_q + {{AW{1'b0}}, push & ~drop};
    rd_d       = rd_q + {{AW{1'b0}}, pop};
    ov_d       = drop | (ov_q & ~clr_flags);
    fe_d       = fire | (fe_q & ~clr_flags);
  end
  always_ff @(posedge CLK_50 or negedge RST_n) begin
    if (!RST_n) begin
      s_q        <= '0;
      d_q        <= '0;
      beat_cnt_q <= '0;
      asm_q      <= '0;
      tmo_q      <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      ov_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      s_q        <= s_d;
      d_q        <= d_d;
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
      tmo_q      <= tmo_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ov_q       <= ov_d;
      fe_q       <= fe_d;
    end
  end
  assign word_out   = mem_q[rd_q[AW-1:0]];
  assign word_valid = ~empty;
  assign fifo_level = wr_q - rd_q;
  assign overflow   = ov_q;
  assign frame_err  = fe_q;
endmodule

// File: tb/tb_cm_link_rx.sv
// tb_cm_link_rx: directed stimulus against a queue-based behavioural model plus literal spot checks
module tb_cm_link_rx;
  localparam int DATA_W = 8, BEATS = 2, DEPTH = 16, TIMEOUT = 32;
  localparam int W = DATA_W * BEATS;
  logic              CLK_50 = 0, RST_n = 0, CLK_inter = 0, word_ready = 0, clr_flags = 0;
  logic [DATA_W-1:0] CM = '0;
  logic [W-1:0]      word_out;
  logic              word_valid, overflow, frame_err;
  logic [4:0]        fifo_level;
  int                errors = 0, checks = 0;
  cm_link_rx #(.DATA_W(DATA_W), .BEATS(BEATS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK_50(CLK_50), .RST_n(RST_n), .CM(CM), .CLK_inter(CLK_inter),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err), .clr_flags(clr_flags)
  );
  always #5 CLK_50 = ~CLK_50;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a strobe rise sampled at edge k lands as a beat at edge k+2, using CM seen at edge k
  logic [DATA_W-1:0] m_part [$];
  logic [W-1:0]      m_q [$];
  logic [W-1:0]      m_w;
  logic [DATA_W-1:0] ev0_d, ev1_d, m_b;
  bit                ev0_v, ev1_v, m_ev, m_prev, m_ov, m_fe, m_pop, m_push, m_fire, m_drop;
  int                m_idle;
  always @(posedge CLK_50) begin
    if (!RST_n) begin
      m_part.delete(); m_q.delete();
      ev0_v = 0; ev1_v = 0; m_prev = 0; m_ov = 0; m_fe = 0; m_idle = 0;
    end else begin
      m_ev = ev1_v; m_b = ev1_d;
      ev1_v = ev0_v; ev1_d = ev0_d;
      ev0_v = CLK_inter && !m_prev; ev0_d = CM; m_prev = CLK_inter;
      m_pop = word_ready && m_q.size() > 0;
      m_push = 0; m_fire = 0;
      if (m_ev) begin
        m_idle = 0;
        if (m_part.size() == BEATS - 1) begin
          m_w = '0;
          foreach (m_part[i]) m_w[i*DATA_W +: DATA_W] = m_part[i];
          m_w[W-1 -: DATA_W] = m_b;
          m_part.delete();
          m_push = 1;
        end else m_part.push_back(m_b);
      end else if (m_part.size() > 0) begin
        if (m_idle == TIMEOUT - 1) begin
          m_fire = 1; m_part.delete(); m_idle = 0;
        end else m_idle++;
      end
      m_drop = m_push && m_q.size() == DEPTH && !m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (m_push && !m_drop) m_q.push_back(m_w);
      m_ov = m_drop || (m_ov && !clr_flags);
      m_fe = m_fire || (m_fe && !clr_flags);
    end
  end
  always @(negedge CLK_50) if (RST_n) begin
    check("model_valid", word_valid, m_q.size() > 0);
    check("model_level", fifo_level, m_q.size());
    check("model_overflow", overflow, m_ov);
    check("model_frame_err", frame_err, m_fe);
    if (m_q.size() > 0) check("model_word", word_out, m_q[0]);
  end
  task automatic cyc();
    @(negedge CLK_50); #1;
  endtask
  // side: 1 pops and 2 clears flags on exactly the edge where this beat lands
  task automatic send_beat(input logic [DATA_W-1:0] b, input int side);
    CM = b; cyc();
    CLK_inter = 1; cyc(); cyc();
    word_ready = side == 1; clr_flags = side == 2; cyc();
    word_ready = 0; clr_flags = 0; CLK_inter = 0;
    cyc(); cyc(); cyc();
  endtask
  task automatic send_word(input logic [W-1:0] w, input int side);
    send_beat(w[7:0], 0);
    send_beat(w[15:8], side);
  endtask
  task automatic drain();
    word_ready = 1; repeat (DEPTH + 4) cyc(); word_ready = 0;
  endtask
  initial begin
    cyc(); cyc();
    check("rst_valid", word_valid, 0); check("rst_level", fifo_level, 0);
    check("rst_ov", overflow, 0); check("rst_fe", frame_err, 0); check("rst_word", word_out, 0);
    RST_n = 1; cyc();
    send_beat(8'h34, 0);
    CM = 8'h12; cyc(); CLK_inter = 1;
    cyc(); check("lat_edge_k", word_valid, 0);
    cyc(); check("lat_edge_k1", word_valid, 0);
    cyc(); check("lat_edge_k2", word_valid, 1);
    check("single_word", word_out, 16'h1234); check("single_level", fifo_level, 1);
    CLK_inter = 0; cyc(); cyc();
    word_ready = 1; cyc(); word_ready = 0;
    check("pop_level", fifo_level, 0); check("pop_valid", word_valid, 0);
    for (int i = 0; i < 17; i++) send_word(W'(i), 0);
    check("fill_level", fifo_level, 16); check("fill_ov", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check("fill_order", word_out, i); word_ready = 1; cyc();
    end
    word_ready = 0; check("fill_empty", word_valid, 0);
    clr_flags = 1; cyc(); clr_flags = 0;
    check("clr_ov", overflow, 0); check("clr_fe", frame_err, 0);
    for (int i = 0; i < 16; i++) send_word(16'h0100 + W'(i), 0);
    send_word(16'h01FF, 1);
    check("simul_level", fifo_level, 16); check("simul_ov", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      check("simul_order", word_out, i < 15 ? 16'h0101 + i : 16'h01FF); word_ready = 1; cyc();
    end
    word_ready = 0;
    send_beat(8'hAA, 0);
    repeat (TIMEOUT + 5) cyc();
    check("tmo_fe", frame_err, 1); check("tmo_level", fifo_level, 0);
    send_beat(8'h01, 0); send_beat(8'h02, 0);
    check("tmo_word", word_out, 16'h0201);
    drain();
    clr_flags = 1; cyc(); clr_flags = 0;
    check("clr_fe2", frame_err, 0);
    for (int i = 0; i < 16; i++) send_word(16'h0300 + W'(i), 0);
    check("pre_drop_ov", overflow, 0);
    send_word(16'h03FF, 2);
    check("set_wins_ov", overflow, 1); check("set_wins_level", fifo_level, 16);
    send_beat(8'h77, 0);
    RST_n = 0; cyc();
    check("mid_rst_valid", word_valid, 0); check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ov", overflow, 0); check("mid_rst_fe", frame_err, 0); check("mid_rst_word", word_out, 0);
    RST_n = 1; cyc();
    send_beat(8'h55, 0); send_beat(8'h66, 0);
    check("post_rst_word", word_out, 16'h6655); check("post_rst_level", fifo_level, 1);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
